// File: rtl/pipe_issue_if.sv
// Issue-stage bus: program load, start control, and the decoded instruction slot
// handed to the execute pipeline, plus status.
interface pipe_issue_if #(
    parameter int AW = 8
);
    logic          start;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [23:0]   load_data;
    logic          out_ready;
    logic          out_valid;
    logic [3:0]    rs1;
    logic [3:0]    rs2;
    logic [3:0]    rd;
    logic [3:0]    func;
    logic [7:0]    addr;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic [15:0]   stall_cnt;

    modport slave (
        input  start, load_en, load_addr, load_data, out_ready,
        output out_valid, rs1, rs2, rd, func, addr, pc, busy, done, stall_cnt
    );

    modport master (
        output start, load_en, load_addr, load_data, out_ready,
        input  out_valid, rs1, rs2, rd, func, addr, pc, busy, done, stall_cnt
    );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// Fetch/issue stage: steps a PC through a 256x24 instruction store, issues one
// instruction per cycle, inserts bubbles on RAW hazards and stops on HALT.
module pipe_issue_ctrl #(
    parameter int           AW        = 8,
    parameter int           HAZ_DEPTH = 2,
    parameter logic [3:0]   HALT_FUNC = 4'hF
) (
    input  logic           clk,
    input  logic           rst,
    pipe_issue_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALTED} state_e;

    state_e                      state_q, state_d;
    logic [AW-1:0]               pc_q, pc_d;
    logic [15:0]                 stall_q, stall_d;
    logic [23:0]                 held_q;
    logic [23:0]                 last_q;
    logic [HAZ_DEPTH-1:0]        hist_vld_q;
    logic [HAZ_DEPTH-1:0][3:0]   hist_rd_q;
    logic [23:0]                 imem [2**AW];

    logic          idle_like, in_issue, is_halt, hazard;
    logic          out_valid, fire;
    logic          hist_clr, hist_push, push_vld;
    logic          mem_re;
    logic [AW-1:0] rd_addr;
    logic [23:0]   out_word;
    logic [3:0]    h_rs1, h_rs2, h_rd, h_func;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign h_func = held_q[23:20];
    assign h_rs1  = held_q[19:16];
    assign h_rs2  = held_q[15:12];
    assign h_rd   = held_q[11:8];

    assign idle_like = (state_q == S_IDLE) || (state_q == S_HALTED);
    assign in_issue  = (state_q == S_ISSUE);
    assign is_halt   = (h_func == HALT_FUNC);

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (hist_vld_q[i] && ((hist_rd_q[i] == h_rs1) || (hist_rd_q[i] == h_rs2)))
                hazard = 1'b1;
        end
    end

    assign out_valid = in_issue && !is_halt && !hazard;
    assign fire      = out_valid && bus.out_ready;

    // The read port serves FETCH (current PC) and the prefetch on each issue (PC+1).
    assign mem_re  = (state_q == S_FETCH) || fire;
    assign rd_addr = (state_q == S_FETCH) ? pc_q : pc_q + AW'(1);

    always_ff @(posedge clk) begin
        if (idle_like && bus.load_en)
            imem[bus.load_addr] <= bus.load_data;
        if (mem_re)
            held_q <= imem[rd_addr];
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        stall_d   = stall_q;
        hist_clr  = 1'b0;
        hist_push = 1'b0;
        push_vld  = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (bus.start) begin
                    state_d  = S_FETCH;
                    pc_d     = '0;
                    stall_d  = '0;
                    hist_clr = 1'b1;
                end
            end
            S_FETCH: state_d = S_ISSUE;
            S_ISSUE: begin
                if (is_halt) begin
                    state_d = S_HALTED;
                end else if (hazard) begin
                    stall_d   = sat_inc16(stall_q);
                    hist_push = 1'b1;
                end else if (bus.out_ready) begin
                    pc_d      = pc_q + AW'(1);
                    hist_push = 1'b1;
                    push_vld  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            stall_q <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stall_q <= stall_d;
            if (out_valid)
                last_q <= held_q;
        end
    end

    // History slot 0 is the most recent issue slot; bubbles shift in an invalid entry.
    always_ff @(posedge clk) begin
        if (rst || hist_clr) begin
            hist_vld_q <= '0;
            hist_rd_q  <= '0;
        end else if (hist_push) begin
            for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
                hist_vld_q[i] <= hist_vld_q[i-1];
                hist_rd_q[i]  <= hist_rd_q[i-1];
            end
            hist_vld_q[0] <= push_vld;
            hist_rd_q[0]  <= h_rd;
        end
    end

    assign out_word      = out_valid ? held_q : last_q;
    assign bus.out_valid = out_valid;
    assign bus.func      = out_word[23:20];
    assign bus.rs1       = out_word[19:16];
    assign bus.rs2       = out_word[15:12];
    assign bus.rd        = out_word[11:8];
    assign bus.addr      = out_word[7:0];
    assign bus.pc        = pc_q;
    assign bus.busy      = (state_q == S_FETCH) || (state_q == S_ISSUE);
    assign bus.done      = (state_q == S_HALTED);
    assign bus.stall_cnt = stall_q;
endmodule

// File: doc/pipe_issue_ctrl.md
Name: pipe_issue_ctrl

Overview:
- Instruction fetch/issue stage sitting directly upstream of the 3-stage register-ALU-memory pipeline.
- Holds a 256 x 24-bit instruction store and steps a program counter through it.
- Presents rs1/rs2/rd/func/addr fields to the execute pipeline one instruction per cycle.
- Inserts bubbles on read-after-write hazards against in-flight destinations, and stops on a HALT opcode.

Parameters:
AW, 8, instruction-store address / PC width (depth 2**AW)
HAZ_DEPTH, 2, number of previously issued slots checked for RAW hazards (legal 1..3)
HALT_FUNC, 4'hF, func code that terminates the program; never issued

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  pulse: begin execution from PC=0 (honoured only in IDLE or HALTED)
load_en  in  1  write load_data into instruction store at load_addr (honoured only in IDLE or HALTED)
load_addr  in  AW  instruction store write address
load_data  in  24  instruction word: [23:20] func, [19:16] rs1, [15:12] rs2, [11:8] rd, [7:0] addr
out_ready  in  1  downstream accepts the current slot
out_valid  out  1  rs1/rs2/rd/func/addr carry a real instruction; low = bubble
rs1, rs2, rd, func  out  4 each  decoded fields to execute pipeline
addr  out  8  memory destination field
pc  out  AW  address of the instruction currently held for issue
busy  out  1  state is FETCH or ISSUE
done  out  1  high in HALTED
stall_cnt  out  16  bubbles inserted since last start; saturates at 16'hFFFF

Behaviour:
- Reset values (any cycle, including mid-program): state=IDLE, pc=0, out_valid=0, all fields=0, busy=0, done=0, stall_cnt=0, hazard history cleared. Instruction store contents are not cleared.
- States and transitions:
  - IDLE: start -> FETCH (pc=0, stall_cnt=0).
  - FETCH: synchronous read of imem[pc] into the instruction holding register -> ISSUE next cycle.
  - ISSUE: each cycle, evaluate the held instruction:
    - func==HALT_FUNC -> HALTED; out_valid=0; pc frozen at the HALT address.
    - hazard (held rs1 or rs2 equals rd of any valid history entry) -> out_valid=0 (bubble); stall_cnt+1; history shifts in an invalid entry.
    - otherwise -> out_valid=1 with the held fields. When out_ready=1 at the edge the slot is issued: history shifts in {valid, rd}, pc+1, and the next word (prefetched) becomes held, so back-to-back issue is one per cycle.
  - HALTED: start -> FETCH (restart at pc=0); load_en honoured.
- out_ready=0 while out_valid=1: outputs, pc and history all hold. A bubble cycle always advances the history regardless of out_ready.
- History is a HAZ_DEPTH-deep shift register of {valid, rd}:
  - Dependency at distance 1 costs HAZ_DEPTH bubbles; at distance 2 costs HAZ_DEPTH-1.
  - rd equal to own rs1/rs2 is not a hazard.
- pc wraps 2**AW-1 -> 0 and continues; no error.
- load_en and start in the same cycle: the write completes first, and the fetch sees the new word.
- load_en and start are ignored in FETCH and ISSUE.
- Fields remain at their last value while out_valid=0.
- First out_valid rises 2 cycles after start is sampled (FETCH, then ISSUE).

Test Plan:
- Load ADD(func0,rs1 3,rs2 5,rd 10,addr 125), MUL(2,3,8,12,126), SUB(1,10,5,14,128), SLA(11,7,3,13,127), SUB(1,10,5,15,129), HALT at 5; start with out_ready=1 -> valid issues ADD, MUL, bubble, SUB, SLA, SUB on consecutive cycles; done=1; pc=5; stall_cnt=1.
- Back-to-back dependency ADD rd=4, then SUB rs2=4 -> exactly 2 bubbles between them (HAZ_DEPTH=2).
- Hold out_ready=0 for 3 cycles on the MUL slot -> fields, pc and out_valid stay constant; sequence then resumes with no lost or duplicated instruction.
- Assert rst during the SUB issue -> next cycle out_valid=0, state IDLE, pc=0; start re-runs the program with the identical issue sequence.
- Fill all 256 words with independent ADDs except a HALT at 3; start at pc 0 -> stops at pc=3. Then reload a HALT at 2 and start again -> stops at pc=2, and stall_cnt is reset.
- load_en during ISSUE -> the instruction store is unchanged; a later read-back via execution shows the original word.
